// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed N-digit hexadecimal seven-segment display driver for
// common-anode displays. A packed nibble bus is captured into a pending
// register on load and handed to the display register only at the start of
// a scan frame, so a frame never shows a mix of old and new digits. Each
// digit gets one slot of SCAN_DIV clocks. The first GUARD clocks of every
// slot keep all anodes off to suppress ghosting.
//
// Parameters
//   NUM_DIGITS   digits scanned (>= 2)
//   SCAN_DIV     clk cycles per digit slot (>= 2)
//   GUARD        anode-off cycles at the start of each slot (0 <= GUARD < SCAN_DIV)
//   SEG_ACT_LOW  1: segs/dp driven low when lit, 0: driven high when lit
//   AN_ACT_LOW   1: anode driven low when on,    0: driven high when on
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active low
//   value       packed digits, digit k = value[4k+3:4k], digit 0 rightmost
//   dp_in       decimal point per digit, 1 = lit
//   load        capture value/dp_in into the pending register
//   blank       1 = all anodes off (scanning continues)
//   segs        segment drive {g,f,e,d,c,b,a}
//   dp          decimal point drive
//   an          anode enables, one-hot when a digit is on
//   digit_idx   digit whose slot is currently running
//   frame_done  one-cycle pulse when the last digit's slot has ended
//
// Optional build macro
//   SEG7_LZB_EN  leading-zero blanking: digit k>0 keeps its anode off when
//                it and every higher display digit are 0 with dp off.
//                Digit 0 is always shown.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int GUARD       = 500,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    input  logic                          blank,
    output logic [6:0]                    segs,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int PRESC_W = $clog2(SCAN_DIV);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] GUARD_END  = PRESC_W'(GUARD);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam bit SEG_LOW = (SEG_ACT_LOW != 0);
    localparam bit AN_LOW  = (AN_ACT_LOW != 0);

    localparam logic [6:0]            SEGS_OFF = SEG_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = SEG_LOW ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_LOW ? {NUM_DIGITS{1'b1}}
                                                        : {NUM_DIGITS{1'b0}};

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_to_segs_n(input logic [3:0] nib);
        logic [6:0] pat;
        pat = 7'h7F;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h18;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            4'hF: pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // State
    logic [PRESC_W-1:0]      presc_reg,      presc_next;
    logic [IDX_W-1:0]        digit_idx_reg,  digit_idx_next;
    logic                    pend_valid_reg, pend_valid_next;
    logic [4*NUM_DIGITS-1:0] pend_value_reg, pend_value_next;
    logic [NUM_DIGITS-1:0]   pend_dp_reg,    pend_dp_next;
    logic [4*NUM_DIGITS-1:0] disp_value_reg, disp_value_next;
    logic [NUM_DIGITS-1:0]   disp_dp_reg,    disp_dp_next;

    // Registered outputs
    logic                    frame_done_reg, frame_done_next;
    logic [6:0]              segs_reg,       segs_next;
    logic                    dp_reg,         dp_next;
    logic [NUM_DIGITS-1:0]   an_reg,         an_next;

    logic                    slot_end;
    logic                    frame_wrap;
    logic [3:0]              disp_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   digit_shown;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [6:0]              segs_lit_n;
    logic                    digit_on;

    assign slot_end   = (presc_reg == PRESC_LAST);
    assign frame_wrap = slot_end && (digit_idx_reg == IDX_LAST);
    assign an_onehot  = NUM_DIGITS'(1) << digit_idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign disp_nib[gi] = disp_value_reg[4*gi +: 4];
        end
    endgenerate

`ifdef SEG7_LZB_EN
    // lz_chain[k] = digits k..NUM_DIGITS-1 are all zero with their dp off.
    // Built from the display register so it tracks frame boundaries exactly.
    logic [NUM_DIGITS:1] lz_chain;
    assign lz_chain[NUM_DIGITS] = 1'b1;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
            assign lz_chain[gi] = lz_chain[gi+1] && (disp_nib[gi] == 4'h0)
                                  && !disp_dp_reg[gi];
        end
    endgenerate
    assign digit_shown = {~lz_chain[NUM_DIGITS-1:1], 1'b1};
`else
    assign digit_shown = {NUM_DIGITS{1'b1}};
`endif

    always_comb begin
        // Scan timing
        presc_next     = presc_reg + PRESC_W'(1);
        digit_idx_next = digit_idx_reg;
        if (slot_end) begin
            presc_next     = '0;
            digit_idx_next = frame_wrap ? '0 : digit_idx_reg + IDX_W'(1);
        end

        // Pending capture: last load before the frame boundary wins.
        pend_valid_next = pend_valid_reg;
        pend_value_next = pend_value_reg;
        pend_dp_next    = pend_dp_reg;
        disp_value_next = disp_value_reg;
        disp_dp_next    = disp_dp_reg;
        if (load) begin
            pend_value_next = value;
            pend_dp_next    = dp_in;
            pend_valid_next = 1'b1;
        end

        // Display updates only on the frame wrap. A load landing on that same
        // edge bypasses the pending register so it is not shown a frame late.
        if (frame_wrap) begin
            if (load) begin
                disp_value_next = value;
                disp_dp_next    = dp_in;
                pend_valid_next = 1'b0;
            end else if (pend_valid_reg) begin
                disp_value_next = pend_value_reg;
                disp_dp_next    = pend_dp_reg;
                pend_valid_next = 1'b0;
            end
        end

        frame_done_next = frame_wrap;

        // Segments always follow the current digit; only the anodes gate.
        segs_lit_n = hex_to_segs_n(disp_nib[digit_idx_reg]);
        segs_next  = SEG_LOW ? segs_lit_n : ~segs_lit_n;
        dp_next    = SEG_LOW ? ~disp_dp_reg[digit_idx_reg] : disp_dp_reg[digit_idx_reg];

        digit_on = (presc_reg >= GUARD_END) && !blank && digit_shown[digit_idx_reg];
        an_next  = AN_OFF;
        if (digit_on) begin
            an_next = AN_LOW ? ~an_onehot : an_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg      <= '0;
            digit_idx_reg  <= '0;
            pend_valid_reg <= 1'b0;
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            disp_value_reg <= '0;
            disp_dp_reg    <= '0;
            frame_done_reg <= 1'b0;
            segs_reg       <= SEGS_OFF;
            dp_reg         <= DP_OFF;
            an_reg         <= AN_OFF;
        end else begin
            presc_reg      <= presc_next;
            digit_idx_reg  <= digit_idx_next;
            pend_valid_reg <= pend_valid_next;
            pend_value_reg <= pend_value_next;
            pend_dp_reg    <= pend_dp_next;
            disp_value_reg <= disp_value_next;
            disp_dp_reg    <= disp_dp_next;
            frame_done_reg <= frame_done_next;
            segs_reg       <= segs_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
        end
    end

    assign segs       = segs_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign digit_idx  = digit_idx_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Scoreboard bench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=4, GUARD=1,
// active-low segments and anodes). At every frame_done the stimulus pushes
// the expected content of the next output frame; the monitor pops it and
// checks all 16 output cycles of that frame.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  segs;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int passes = 0;
    int frames_checked = 0;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        logic        b;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    logic [6:0] dec_tab [16];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .GUARD      (1),
        .SEG_ACT_LOW(1),
        .AN_ACT_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .blank     (blank),
        .segs      (segs),
        .dp        (dp),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_an"},         32'(an),         32'h0000_000F);
        check({tag, "_segs"},       32'(segs),       32'h0000_007F);
        check({tag, "_dp"},         32'(dp),         32'h0000_0001);
        check({tag, "_digit_idx"},  32'(digit_idx),  32'h0000_0000);
        check({tag, "_frame_done"}, 32'(frame_done), 32'h0000_0000);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        if (!frame_done) begin
            checks++;
            $display("FAIL frame_done_timeout: got no pulse in %0d cycles, required one within 16", n);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] d, input logic b, input int id);
        exp_t e;
        e.v  = v;
        e.d  = d;
        e.b  = b;
        e.id = id;
        exp_q.push_back(e);
        $display("frame %0d expected: value=%h dp=%b blank=%0d", id, v, d, b);
    endtask

    // Monitor: sample j of a frame (0..15) shows the DUT state of slot j/4,
    // prescaler j%4, one cycle late; frame_done is expected only at j=15.
    exp_t       cur;
    int         mon_j = 0;
    bit         in_frame = 1'b0;
    always @(negedge clk) begin : monitor
        int         sd;
        int         sp;
        logic [3:0] nib;
        logic [3:0] e_an;
        logic [1:0] e_idx;
        logic       vis;
        if (!rst_n) begin
            in_frame = 1'b0;
            mon_j    = 0;
        end else if (in_frame) begin
            if (mon_j == 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_underflow: got empty queue, required an expected frame");
                    in_frame = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            if (in_frame) begin
                sd  = mon_j / 4;
                sp  = mon_j % 4;
                nib = cur.v[4*sd +: 4];
                vis = 1'b1;
`ifdef SEG7_LZB_EN
                if (sd > 0) begin
                    vis = 1'b0;
                    for (int i = sd; i < 4; i++) begin
                        if (cur.v[4*i +: 4] != 4'h0 || cur.d[i]) vis = 1'b1;
                    end
                end
`endif
                e_an  = (sp >= 1 && !cur.b && vis) ? ~(4'b0001 << sd) : 4'hF;
                e_idx = 2'(((mon_j + 1) / 4) % 4);
                check($sformatf("frame%0d_cyc%0d{an,segs,dp,idx,fd}", cur.id, mon_j),
                      32'({an, segs, dp, digit_idx, frame_done}),
                      32'({e_an, dec_tab[nib], ~cur.d[sd], e_idx, (mon_j == 15)}));
                mon_j++;
                if (mon_j == 16) begin
                    mon_j = 0;
                    frames_checked++;
                end else if (frame_done) begin
                    mon_j = 0;
                end
            end
        end else if (frame_done) begin
            in_frame = 1'b1;
            mon_j    = 0;
        end
    end

    initial begin
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Power-on reset: outputs must go inactive before any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset("por");
        cycles(2);
        rst_n = 1'b1;

        // Pending load before the first frame boundary.
        @(negedge clk);
        do_load(16'h12AF, 4'h0);
        wait_fd();

        // Frame 1: 12AF; a mid-frame load of 0000 must not tear it.
        push(16'h12AF, 4'h0, 1'b0, 1);
        cycles(5);
        do_load(16'h0000, 4'b0101);
        wait_fd();

        // Frame 2: 0000 with dp; two loads inside it, only the last survives.
        push(16'h0000, 4'b0101, 1'b0, 2);
        cycles(3);
        do_load(16'h1111, 4'hF);
        cycles(4);
        do_load(16'h9ABC, 4'b0010);
        wait_fd();

        // Frame 3: 9ABC; pending 7777 then a load on the wrap edge itself.
        push(16'h9ABC, 4'b0010, 1'b0, 3);
        cycles(4);
        do_load(16'h7777, 4'h0);
        cycles(10);
        value = 16'h5555;
        dp_in = 4'b1000;
        load  = 1'b1;
        wait_fd();
        load  = 1'b0;

        // Frame 4: wrap-edge data shown immediately.
        push(16'h5555, 4'b1000, 1'b0, 4);
        wait_fd();

        // Frame 5: blanked; scan and frame_done continue.
        push(16'h5555, 4'b1000, 1'b1, 5);
        blank = 1'b1;
        wait_fd();
        blank = 1'b0;

        // Frame 6: partially observed, then an asynchronous reset mid-scan
        // drops the pending AAAA load.
        push(16'h5555, 4'b1000, 1'b0, 6);
        cycles(3);
        do_load(16'hAAAA, 4'hF);
        cycles(4);
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        cycles(2);
        check_reset("midrst_hold");
        rst_n = 1'b1;
        wait_fd();

        // Frame 7: display cleared by reset, pending data gone.
        push(16'h0000, 4'h0, 1'b0, 7);
        wait_fd();
        #1;

        check("frames_checked", 32'(frames_checked), 32'd6);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
